stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, giving input clock cycles per tick period (1 s).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 1000000, giving the stable-input cycles required to accept a button level change (20 ms at 50 MHz).
REQ-003 The block SHALL have port CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port BUTTON  input  2  raw asynchronous buttons, active-low; [1] = start/stop, [0] = clear (lap when configured).
REQ-006 The block SHALL have port tick  output  1  one-cycle count-enable pulse to the sec/min counter.
REQ-007 The block SHALL have port clr  output  1  one-cycle synchronous clear pulse to the sec/min counter.
REQ-008 The block SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
REQ-009 The block SHALL have port disp_hold  output  1  display freeze request to the decoder path.

Function
REQ-010 Each BUTTON bit SHALL pass a 2-FF synchronizer and then a debouncer; the debounced level SHALL change only after DEB_CYCLES consecutive cycles of a differing synchronized level.
REQ-011 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; release SHALL generate no event; a held button SHALL generate exactly one event.
REQ-012 On a start/stop event, FSM transitions SHALL be IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-013 On a clear event in IDLE or PAUSE, the FSM SHALL go to IDLE and clr SHALL pulse in the next cycle; a clear event in RUN SHALL NOT change state.
REQ-014 Simultaneous events in one cycle: in IDLE/PAUSE clear SHALL win and start/stop SHALL be dropped; in RUN start/stop SHALL win.
REQ-015 The prescaler, width $clog2(CLK_HZ), SHALL increment only in RUN, hold its value in PAUSE (partial second preserved), and be zeroed on IDLE entry.
REQ-016 tick SHALL assert for one cycle when state is RUN and the prescaler equals CLK_HZ-1; the prescaler SHALL wrap to 0 in that cycle.
REQ-017 If a stop event coincides with the terminal prescaler count, tick SHALL still be issued, since it is decided by the current state.
REQ-018 The first tick after IDLE->RUN SHALL occur exactly CLK_HZ cycles after the cycle in which RUN is entered.
REQ-019 tick and clr SHALL never be asserted in the same cycle.

Reset
REQ-020 While RESET is high: state = IDLE, prescaler = 0, tick = 0, clr = 0, disp_hold = 0, synchronizer and debounced levels = 1 (released), debounce counters = 0.
REQ-021 RESET asserted mid-RUN SHALL override all events in that cycle; no tick or clr pulse SHALL be generated for it, because the counter shares RESET.

Configuration
REQ-022 Macro STOPWATCH_LAP_EN: when defined, a clear event in RUN SHALL toggle disp_hold; disp_hold SHALL clear on any transition to PAUSE or IDLE.
REQ-023 Without STOPWATCH_LAP_EN, disp_hold SHALL be tied to 0 and a clear event in RUN SHALL be ignored.

Structure
REQ-024 Package stopwatch_pkg SHALL hold the state encoding (IDLE/RUN/PAUSE) and the default CLK_HZ and DEB_CYCLES constants.
REQ-025 Sub-module button_debounce (synchronizer, debouncer, press-event pulse) SHALL be instantiated once per BUTTON bit.

Verification (CLK_HZ=10, DEB_CYCLES=4)
REQ-026 RESET 1 cycle, BUTTON=11 -> state=00; tick, clr and disp_hold = 0 throughout.
REQ-027 BUTTON[1] low for 3 cycles then high (glitch) -> no event, state stays 00.
REQ-028 BUTTON[1] pressed, held 20 cycles -> state=01 once; first tick 10 cycles after RUN entry, then every 10 cycles.
REQ-029 RUN, stop at prescaler=6, resume after 50 cycles -> next tick 3 cycles after RUN re-entry.
REQ-030 PAUSE, both buttons pressed in the same cycle -> state=00, clr pulses once, no RUN entry.
REQ-031 With STOPWATCH_LAP_EN, BUTTON[0] pressed in RUN -> disp_hold=1 and ticks continue; a subsequent stop -> disp_hold=0, state=10.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Stopwatch control shared types: FSM state encoding
// and default timing constants for stopwatch_ctrl.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } sw_state_e;

  localparam int unsigned DEF_CLK_HZ     = 50000000;
  localparam int unsigned DEF_DEB_CYCLES = 1000000;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-FF sync, debouncer, one-cycle press pulse.
// Ports: clk, rst (sync high), btn_n (raw, active-low), press.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
          // only the released->pressed edge is an event
          press <= level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop/clear buttons -> tick, clr.
// Ports: CLOCK_50, RESET, BUTTON[1:0], tick, clr, state, disp_hold.
// Optional lap hold: define STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] BUTTON,
  output logic       tick,
  output logic       clr,
  output logic [1:0] state,
  output logic       disp_hold
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

  logic [1:0]    ev;
  sw_state_e     st;
  logic [PW-1:0] presc;
  logic          ev_ss;
  logic          ev_clr;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    button_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (CLOCK_50),
      .rst  (RESET),
      .btn_n(BUTTON[i]),
      .press(ev[i])
    );
  end

  assign ev_ss  = ev[1];
  assign ev_clr = ev[0];
  assign state  = st;

`ifdef STOPWATCH_LAP_EN
  logic hold;
  assign disp_hold = hold;
`else
  assign disp_hold = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      st    <= IDLE;
      presc <= '0;
      tick  <= 1'b0;
      clr   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      hold  <= 1'b0;
`endif
    end else begin
      // tick follows the current state, so a stop
      // at the terminal count still emits it
      tick <= (st == RUN) && (presc == TERM);
      clr  <= 1'b0;
      if (st == RUN)
        presc <= (presc == TERM) ? '0 : presc + 1'b1;
      unique case (st)
        IDLE: begin
          if (ev_clr)
            clr <= 1'b1;
          else if (ev_ss)
            st <= RUN;
        end
        PAUSE: begin
          if (ev_clr) begin
            st    <= IDLE;
            presc <= '0;
            clr   <= 1'b1;
          end else if (ev_ss) begin
            st <= RUN;
          end
        end
        RUN: begin
          if (ev_ss) begin
            st <= PAUSE;
`ifdef STOPWATCH_LAP_EN
            hold <= 1'b0;
          end else if (ev_clr) begin
            hold <= ~hold;
`endif
          end
        end
        default: begin
          st    <= IDLE;
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (CLK_HZ=10, DEB_CYCLES=4).
module tb_stopwatch_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
`ifdef STOPWATCH_LAP_EN
  localparam int LAP = 1;
`else
  localparam int LAP = 0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic [1:0] BUTTON;
  logic       tick;
  logic       clr;
  logic [1:0] state;
  logic       disp_hold;

  stopwatch_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .DEB_CYCLES(DEB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .BUTTON   (BUTTON),
    .tick     (tick),
    .clr      (clr),
    .state    (state),
    .disp_hold(disp_hold)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_n = 0;
  int clr_n = 0;
  int run_n = 0;
  int both_n = 0;
  int hold_bad = 0;
  int last_tick = 0;
  int run_cyc = 0;
  int pause_cyc = 0;
  int idle_cyc = 0;
  int clr_cyc = 0;
  logic [1:0] prev_st = 2'b00;

  always @(negedge CLOCK_50) begin
    cyc++;
    if (tick) begin
      tick_n++;
      last_tick = cyc;
    end
    if (clr) begin
      clr_n++;
      clr_cyc = cyc;
    end
    if (tick && clr) both_n++;
    if (LAP == 0 && disp_hold) hold_bad++;
    if (state != prev_st) begin
      if (state == 2'b01) begin
        run_n++;
        run_cyc = cyc;
      end
      if (state == 2'b10) pause_cyc = cyc;
      if (state == 2'b00) idle_cyc = cyc;
    end
    prev_st = state;
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      #1;
    end
  endtask

  task automatic wait_state(input logic [1:0] s,
                            input int budget);
    int k = 0;
    while (state != s && k < budget) begin
      step(1);
      k++;
    end
    chk("reach_state", int'(state), int'(s));
  endtask

  task automatic wait_tick(input int budget);
    int t0 = tick_n;
    int k = 0;
    while (tick_n == t0 && k < budget) begin
      step(1);
      k++;
    end
    chk("tick_seen", int'(tick_n > t0), 1);
  endtask

  int t, p, tn, cn, r;

  initial begin
    RESET  = 1'b1;
    BUTTON = 2'b11;
    step(2);
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_clr", int'(clr), 0);
    chk("rst_hold", int'(disp_hold), 0);
    RESET = 1'b0;
    step(1);

    // 3-cycle glitch must be filtered
    BUTTON[1] = 1'b0;
    step(3);
    BUTTON = 2'b11;
    step(12);
    chk("glitch_state", int'(state), 0);
    chk("glitch_runs", run_n, 0);

    // held start: one entry, ticks every 10
    BUTTON[1] = 1'b0;
    t = cyc;
    wait_state(2'b01, 20);
    chk("run_latency", run_cyc - t, 7);
    wait_tick(15);
    chk("first_tick", last_tick - run_cyc, 10);
    while (cyc - t < 20) step(1);
    BUTTON = 2'b11;
    p = last_tick;
    wait_tick(15);
    chk("tick_period", last_tick - p, 10);
    chk("run_once", run_n, 1);

    // stop with prescaler at 6, resume after 50
    wait_tick(15);
    t = cyc;
    BUTTON[1] = 1'b0;
    wait_state(2'b10, 20);
    chk("stop_at6", pause_cyc - t, 7);
    step(10);
    BUTTON = 2'b11;
    tn = tick_n;
    while (cyc - pause_cyc < 50) step(1);
    chk("pause_no_tick", tick_n - tn, 0);
    chk("pause_state", int'(state), 2);
    BUTTON[1] = 1'b0;
    wait_state(2'b01, 20);
    wait_tick(15);
    chk("resume_tick", last_tick - run_cyc, 3);
    BUTTON = 2'b11;
    step(10);

    // clear in RUN: lap toggle or ignored
    BUTTON[0] = 1'b0;
    step(12);
    BUTTON = 2'b11;
    step(8);
    chk("lap_state", int'(state), 1);
    chk("lap_hold", int'(disp_hold), LAP);
    chk("lap_no_clr", clr_n, 0);
    p = last_tick;
    wait_tick(15);
    chk("lap_tick_period", last_tick - p, 10);
    BUTTON[1] = 1'b0;
    wait_state(2'b10, 20);
    chk("stop_hold", int'(disp_hold), 0);
    step(10);
    BUTTON = 2'b11;
    step(10);

    // both buttons in PAUSE: clear wins
    r = run_n;
    BUTTON = 2'b00;
    t = cyc;
    wait_state(2'b00, 20);
    chk("both_latency", idle_cyc - t, 7);
    step(12);
    BUTTON = 2'b11;
    step(10);
    chk("both_clr_once", clr_n, 1);
    chk("both_clr_cyc", clr_cyc - idle_cyc, 0);
    chk("both_no_run", run_n - r, 0);
    chk("both_state", int'(state), 0);

    // restart from IDLE: prescaler was zeroed
    BUTTON[1] = 1'b0;
    wait_state(2'b01, 20);
    wait_tick(15);
    chk("idle_run_tick", last_tick - run_cyc, 10);
    BUTTON = 2'b11;
    step(8);

    // stop landing on the terminal count
    wait_tick(15);
    t = cyc;
    step(3);
    BUTTON[1] = 1'b0;
    wait_state(2'b10, 20);
    chk("term_pause", pause_cyc - t, 10);
    chk("term_tick", last_tick - t, 10);
    step(8);
    BUTTON = 2'b11;
    step(10);

    // reset mid-RUN just before a tick
    BUTTON[1] = 1'b0;
    wait_state(2'b01, 20);
    BUTTON = 2'b11;
    wait_tick(15);
    tn = tick_n;
    cn = clr_n;
    step(8);
    RESET = 1'b1;
    step(3);
    RESET = 1'b0;
    step(12);
    chk("rst_run_state", int'(state), 0);
    chk("rst_run_tick", tick_n - tn, 0);
    chk("rst_run_clr", clr_n - cn, 0);

    chk("tick_clr_excl", both_n, 0);
    chk("hold_tied", hold_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
